// File: rtl/preempt_timer_pkg.sv
// Shared definitions for the preemption quantum timer: FSM state encoding and
// default sizing.
package preempt_timer_pkg;

    localparam int NUM_PROC_DEF = 4;
    localparam int CNT_W_DEF    = 6;
    localparam int EVT_W_DEF    = 8;

    localparam logic [CNT_W_DEF-1:0] DEFAULT_QUANTUM_DEF = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HELD = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

endpackage

// File: rtl/quantum_table.sv
// Per-process quantum register file: one synchronous write port and one
// combinational read port. Every slot resets to the default quantum.
module quantum_table
    import preempt_timer_pkg::*;
#(
    parameter int                 NUM_PROC        = NUM_PROC_DEF,
    parameter int                 CNT_W           = CNT_W_DEF,
    parameter int                 PID_W           = $clog2(NUM_PROC),
    parameter logic [CNT_W-1:0]   DEFAULT_QUANTUM = {CNT_W{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [PID_W-1:0] wr_pid,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [PID_W-1:0] rd_pid,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] slot [NUM_PROC];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                slot[i] <= DEFAULT_QUANTUM;
            end
        end else if (we) begin
            slot[wr_pid] <= wr_data;
        end
    end

    // A write and a read of the same slot in one cycle returns the old value.
    assign rd_data = slot[rd_pid];

endmodule

// File: rtl/preempt_quantum_timer.sv
// Per-process preemption timer: counts enabled ticks against the active slot's
// quantum and posts a held preemption request to the control unit.
//
// state | meaning
// RUN   | counting enabled ticks toward the active quantum
// HELD  | quantum expired while masked; request deferred until mask drops
// REQ   | request posted (preempt_req rises next cycle); waiting for ack
module preempt_quantum_timer
    import preempt_timer_pkg::*;
#(
    parameter int               NUM_PROC        = NUM_PROC_DEF,
    parameter int               PID_W           = $clog2(NUM_PROC),
    parameter int               CNT_W           = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_QUANTUM = {CNT_W{1'b1}},
    parameter int               EVT_W           = EVT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             count_en,
    input  logic             switch_i,
    input  logic [PID_W-1:0] cur_pid,
    input  logic             cfg_we,
    input  logic [PID_W-1:0] cfg_pid,
    input  logic [CNT_W-1:0] cfg_quantum,
    input  logic             mask,
    input  logic             preempt_ack,
    output logic             preempt_req,
    output logic [PID_W-1:0] preempt_pid,
    output logic [CNT_W-1:0] count,
    output logic [EVT_W-1:0] evt_count
);

    state_t           state;
    logic [PID_W-1:0] active_pid;
    logic [CNT_W-1:0] quantum;

    quantum_table #(
        .NUM_PROC        (NUM_PROC),
        .CNT_W           (CNT_W),
        .PID_W           (PID_W),
        .DEFAULT_QUANTUM (DEFAULT_QUANTUM)
    ) u_quantum_table (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (cfg_we),
        .wr_pid  (cfg_pid),
        .wr_data (cfg_quantum),
        .rd_pid  (active_pid),
        .rd_data (quantum)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            active_pid  <= '0;
            count       <= '0;
            preempt_req <= 1'b0;
            evt_count   <= '0;
        end else if (switch_i) begin
            // A context switch discards any pending expiry without counting it.
            state       <= ST_RUN;
            active_pid  <= cur_pid;
            count       <= '0;
            preempt_req <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (count_en) begin
                        if (count >= quantum) begin
                            count <= '0;
                            state <= mask ? ST_HELD : ST_REQ;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (!mask) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (preempt_ack) begin
                        state       <= ST_RUN;
                        preempt_req <= 1'b0;
                        if (evt_count != {EVT_W{1'b1}}) begin
                            evt_count <= evt_count + EVT_W'(1);
                        end
                    end else begin
                        preempt_req <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    preempt_req <= 1'b0;
                end
            endcase
        end
    end

    assign preempt_pid = active_pid;

endmodule

// File: tb/tb_preempt_quantum_timer.sv
// Scoreboard bench: stimulus queues expected snapshots and request rises; a
// negedge monitor pops and compares them against the timer outputs.
module tb_preempt_quantum_timer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       count_en = 1'b0;
    logic       switch_i = 1'b0;
    logic [1:0] cur_pid = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_pid = '0;
    logic [5:0] cfg_quantum = '0;
    logic       mask = 1'b0;
    logic       preempt_ack = 1'b0;
    logic       preempt_req;
    logic [1:0] preempt_pid;
    logic [5:0] count;
    logic [7:0] evt_count;

    preempt_quantum_timer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .count_en    (count_en),
        .switch_i    (switch_i),
        .cur_pid     (cur_pid),
        .cfg_we      (cfg_we),
        .cfg_pid     (cfg_pid),
        .cfg_quantum (cfg_quantum),
        .mask        (mask),
        .preempt_ack (preempt_ack),
        .preempt_req (preempt_req),
        .preempt_pid (preempt_pid),
        .count       (count),
        .evt_count   (evt_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       req;
        logic [1:0] pid;
        logic [5:0] cnt;
        logic [7:0] evt;
    } snap_t;

    typedef struct {
        logic [1:0] pid;
        int         cyc;
    } rise_t;

    snap_t snap_q[$];
    rise_t rise_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  req_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (snap_q.size() > 0) begin
            snap_t e;
            e = snap_q.pop_front();
            checks++;
            if (preempt_req !== e.req || preempt_pid !== e.pid ||
                count !== e.cnt || evt_count !== e.evt) begin
                errors++;
                $display("FAIL %s: got req=%0b pid=%0d count=%0d evt=%0d, expected req=%0b pid=%0d count=%0d evt=%0d",
                         e.name, preempt_req, preempt_pid, count, evt_count,
                         e.req, e.pid, e.cnt, e.evt);
            end
        end
        if (preempt_req === 1'b1 && req_prev !== 1'b1) begin
            checks++;
            if (rise_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: req rose at cycle %0d pid=%0d, expected no request", cyc, preempt_pid);
            end else begin
                rise_t r;
                r = rise_q.pop_front();
                if (preempt_pid !== r.pid || cyc != r.cyc) begin
                    errors++;
                    $display("FAIL req_rise: got pid=%0d at cycle %0d, expected pid=%0d at cycle %0d",
                             preempt_pid, cyc, r.pid, r.cyc);
                end
            end
        end
        req_prev = preempt_req;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string n, input logic r, input logic [1:0] p,
                         input logic [5:0] c, input logic [7:0] e);
        snap_q.push_back('{n, r, p, c, e});
        @(negedge clock);
        #1;
    endtask

    task automatic expect_rise(input logic [1:0] p, input int delay);
        rise_q.push_back('{p, cyc + delay});
    endtask

    task automatic ack_once();
        preempt_ack = 1'b1;
        tick();
        preempt_ack = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 50000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #22 reset_n = 1'b1;
        tick();
        check("reset", 1'b0, 2'd0, 6'd0, 8'd0);

        // Default quantum 63 on slot 0 with continuous ticks.
        expect_rise(2'd0, 65);
        count_en = 1'b1;
        repeat (63) tick();
        check("q63_count63", 1'b0, 2'd0, 6'd63, 8'd0);
        tick();
        check("q63_expired", 1'b0, 2'd0, 6'd0, 8'd0);
        tick();
        check("q63_req", 1'b1, 2'd0, 6'd0, 8'd0);
        ack_once();
        count_en = 1'b0;
        check("q63_ack", 1'b0, 2'd0, 6'd0, 8'd1);

        // Slot 1 quantum 3, ticks enabled every other cycle.
        cfg_we = 1'b1; cfg_pid = 2'd1; cfg_quantum = 6'd3;
        tick();
        cfg_we = 1'b0;
        switch_i = 1'b1; cur_pid = 2'd1;
        tick();
        switch_i = 1'b0;
        check("switch_pid1", 1'b0, 2'd1, 6'd0, 8'd1);
        expect_rise(2'd1, 8);
        for (int i = 0; i < 8; i++) begin
            count_en = (i % 2 == 0);
            tick();
        end
        count_en = 1'b0;
        check("q3_toggle_req", 1'b1, 2'd1, 6'd0, 8'd1);
        ack_once();
        check("q3_ack", 1'b0, 2'd1, 6'd0, 8'd2);

        // Masked expiry is deferred in HELD.
        mask = 1'b1; count_en = 1'b1;
        repeat (14) tick();
        check("held_masked", 1'b0, 2'd1, 6'd0, 8'd2);
        expect_rise(2'd1, 2);
        mask = 1'b0;
        tick();
        check("held_to_req", 1'b0, 2'd1, 6'd0, 8'd2);
        tick();
        check("held_req_high", 1'b1, 2'd1, 6'd0, 8'd2);

        // Switch beats ack in the same cycle: no event counted.
        switch_i = 1'b1; preempt_ack = 1'b1; cur_pid = 2'd2; count_en = 1'b0;
        tick();
        switch_i = 1'b0; preempt_ack = 1'b0;
        check("switch_over_ack", 1'b0, 2'd2, 6'd0, 8'd2);

        // Lowering the active quantum below count expires on the next tick.
        count_en = 1'b1;
        repeat (10) tick();
        count_en = 1'b0;
        check("count10", 1'b0, 2'd2, 6'd10, 8'd2);
        cfg_we = 1'b1; cfg_pid = 2'd2; cfg_quantum = 6'd5;
        tick();
        cfg_we = 1'b0;
        check("lower_q_idle", 1'b0, 2'd2, 6'd10, 8'd2);
        expect_rise(2'd2, 2);
        count_en = 1'b1;
        tick();
        count_en = 1'b0;
        check("lower_q_expire", 1'b0, 2'd2, 6'd0, 8'd2);
        tick();
        check("lower_q_req", 1'b1, 2'd2, 6'd0, 8'd2);
        ack_once();
        check("lower_q_ack", 1'b0, 2'd2, 6'd0, 8'd3);

        // Same-cycle write still compares against the old quantum.
        cfg_we = 1'b1; cfg_pid = 2'd2; cfg_quantum = 6'd0; count_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("old_q_same_cycle", 1'b0, 2'd2, 6'd1, 8'd3);
        expect_rise(2'd2, 2);
        tick();
        count_en = 1'b0;
        check("new_q_expire", 1'b0, 2'd2, 6'd0, 8'd3);
        tick();
        check("new_q_req", 1'b1, 2'd2, 6'd0, 8'd3);
        ack_once();
        check("new_q_ack", 1'b0, 2'd2, 6'd0, 8'd4);

        // Quantum 0 expires on the very first enabled tick.
        expect_rise(2'd2, 2);
        count_en = 1'b1;
        tick();
        check("q0_expire", 1'b0, 2'd2, 6'd0, 8'd4);
        tick();
        count_en = 1'b0;
        check("q0_req", 1'b1, 2'd2, 6'd0, 8'd4);
        ack_once();
        check("q0_ack", 1'b0, 2'd2, 6'd0, 8'd5);

        // Ack held with Q=0: an event every two cycles, saturating at 255.
        preempt_ack = 1'b1; count_en = 1'b1;
        repeat (520) tick();
        preempt_ack = 1'b0; count_en = 1'b0;
        check("evt_saturate", 1'b0, 2'd2, 6'd0, 8'hFF);

        expect_rise(2'd2, 2);
        count_en = 1'b1;
        tick();
        tick();
        count_en = 1'b0;
        check("req_before_reset", 1'b1, 2'd2, 6'd0, 8'hFF);
        #2 reset_n = 1'b0;
        check("async_reset_mid_req", 1'b0, 2'd0, 6'd0, 8'd0);
        reset_n = 1'b1;
        tick();
        check("after_reset", 1'b0, 2'd0, 6'd0, 8'd0);

        @(negedge clock);
        #1;
        checks++;
        if (rise_q.size() != 0) begin
            errors++;
            $display("FAIL missing_req: %0d expected request rises never seen, expected 0", rise_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
